// File: rtl/icetap_data_shift.sv
// rtl/icetap_data_shift.sv - sample-word fetch and LSB-first bit shifter feeding the SPI front end
module icetap_data_shift #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  scan_clk,
   input  logic                  scan_reset,
   input  logic                  data_shift_update,
   input  logic                  data_shift_ena,
   output logic                  data_shift_data,
   input  logic                  rd_start_load,
   input  logic [ADDR_WIDTH-1:0] rd_start_addr,
   output logic                  mem_rd_ena,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  underrun
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD    = 2'd1,
      LOAD  = 2'd2,
      SHIFT = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                  data_q, data_d;
   logic                  underrun_q, underrun_d;

   always_ff @(posedge scan_clk or posedge scan_reset) begin
      if (scan_reset) begin
         state_q    <= IDLE;
         rd_addr_q  <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         data_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         data_q     <= data_d;
         underrun_q <= underrun_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rd_addr_d  = rd_addr_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      data_d     = data_q;
      underrun_d = underrun_q;

      if (rd_start_load) begin
         rd_addr_d  = rd_start_addr;
         state_d    = IDLE;
         bit_cnt_d  = '0;
         underrun_d = 1'b0;
         data_d     = 1'b0;
      end else if (data_shift_update) begin
         // Restart re-reads the current word; the ena of this cycle is dropped.
         state_d   = RD;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (data_shift_ena) underrun_d = 1'b1;
            end
            RD: begin
               if (data_shift_ena) underrun_d = 1'b1;
               state_d = LOAD;
            end
            LOAD: begin
               if (data_shift_ena) underrun_d = 1'b1;
               shreg_d   = mem_rd_data;
               bit_cnt_d = '0;
               data_d    = mem_rd_data[0];
               state_d   = SHIFT;
            end
            SHIFT: begin
               if (data_shift_ena) begin
                  shreg_d   = {1'b0, shreg_q[DATA_WIDTH-1:1]};
                  data_d    = shreg_q[1];
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  // Last bit consumed: advance and prefetch the next word.
                  if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                     bit_cnt_d = '0;
                     rd_addr_d = rd_addr_q + 1'b1;
                     state_d   = RD;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign mem_rd_ena      = (state_q == RD);
   assign mem_rd_addr     = rd_addr_q;
   assign rd_addr         = rd_addr_q;
   assign data_shift_data = data_q;
   assign underrun        = underrun_q;

endmodule

// File: tb/tb_icetap_data_shift.sv
// tb/tb_icetap_data_shift.sv - directed self-checking bench for icetap_data_shift
module tb_icetap_data_shift;

   logic        scan_clk = 1'b0;
   logic        scan_reset;
   logic        data_shift_update;
   logic        data_shift_ena;
   logic        data_shift_data;
   logic        rd_start_load;
   logic [7:0]  rd_start_addr;
   logic        mem_rd_ena;
   logic [7:0]  mem_rd_addr;
   logic [15:0] mem_rd_data;
   logic [7:0]  rd_addr;
   logic        underrun;

   logic [15:0] ram [256];
   int tests_run = 0;
   int tests_failed = 0;

   icetap_data_shift #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
      .scan_clk          (scan_clk),
      .scan_reset        (scan_reset),
      .data_shift_update (data_shift_update),
      .data_shift_ena    (data_shift_ena),
      .data_shift_data   (data_shift_data),
      .rd_start_load     (rd_start_load),
      .rd_start_addr     (rd_start_addr),
      .mem_rd_ena        (mem_rd_ena),
      .mem_rd_addr       (mem_rd_addr),
      .mem_rd_data       (mem_rd_data),
      .rd_addr           (rd_addr),
      .underrun          (underrun)
   );

   always #5 scan_clk = ~scan_clk;

   // RAM model: data valid exactly one cycle after the strobe
   always @(posedge scan_clk) begin
      if (mem_rd_ena) mem_rd_data <= ram[mem_rd_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge scan_clk);
      #1;
   endtask

   task automatic load_addr(input logic [7:0] a);
      rd_start_load = 1'b1;
      rd_start_addr = a;
      tick();
      rd_start_load = 1'b0;
   endtask

   // Update, then walk RD and LOAD; leaves the caller at bit0 visible
   task automatic fetch(input string tag, input logic [7:0] a, input logic [15:0] w);
      data_shift_update = 1'b1;
      tick();
      data_shift_update = 1'b0;
      check({tag, "_rd_ena"}, mem_rd_ena, 1);
      check({tag, "_rd_addr"}, mem_rd_addr, a);
      tick();
      check({tag, "_ld_ena"}, mem_rd_ena, 0);
      tick();
      check({tag, "_bit0"}, data_shift_data, w[0]);
   endtask

   task automatic ena_pulse();
      data_shift_ena = 1'b1;
      tick();
      data_shift_ena = 1'b0;
   endtask

   initial begin
      logic [15:0] w;
      for (int i = 0; i < 256; i++) ram[i] = 16'(i * 16'h0101) ^ 16'h5A3C;
      ram[8'h10] = 16'hA5C3;
      ram[8'h11] = 16'h3C3D;
      ram[8'hFF] = 16'h8001;
      ram[8'h00] = 16'h7FFF;
      ram[8'h20] = 16'h1234;

      scan_reset = 1'b1;
      data_shift_update = 1'b0;
      data_shift_ena = 1'b0;
      rd_start_load = 1'b0;
      rd_start_addr = 8'h00;
      mem_rd_data = 16'h0000;
      tick();
      tick();
      check("rst_data", data_shift_data, 0);
      check("rst_ena", mem_rd_ena, 0);
      check("rst_addr", rd_addr, 0);
      check("rst_underrun", underrun, 0);
      scan_reset = 1'b0;

      // ena in IDLE: underrun set, data stays 0, load clears it
      ena_pulse();
      check("idle_underrun", underrun, 1);
      check("idle_data", data_shift_data, 0);
      load_addr(8'h10);
      check("load_clr_underrun", underrun, 0);
      check("load_addr", rd_addr, 8'h10);

      // Main word with hold-between-pulses checks
      w = 16'hA5C3;
      fetch("w10", 8'h10, w);
      for (int k = 1; k <= 16; k++) begin
         ena_pulse();
         check($sformatf("w10_bit%0d", k), data_shift_data, (k < 16) ? 32'(w[k]) : 32'd0);
         if (k < 16) begin
            tick();
            check($sformatf("w10_hold%0d", k), data_shift_data, (k < 16) ? 32'(w[k]) : 32'd0);
            check($sformatf("w10_addr%0d", k), rd_addr, 8'h10);
         end
      end
      check("adv_addr", rd_addr, 8'h11);
      check("adv_rd_ena", mem_rd_ena, 1);
      check("adv_mem_addr", mem_rd_addr, 8'h11);
      tick();
      check("adv_load_ena", mem_rd_ena, 0);
      tick();
      check("w11_bit0", data_shift_data, 1);
      check("no_underrun", underrun, 0);

      // Address wrap 0xFF -> 0x00
      load_addr(8'hFF);
      fetch("wff", 8'hFF, 16'h8001);
      for (int k = 0; k < 16; k++) ena_pulse();
      check("wrap_addr", rd_addr, 8'h00);
      check("wrap_rd_ena", mem_rd_ena, 1);
      check("wrap_mem_addr", mem_rd_addr, 8'h00);
      tick();
      tick();
      check("w00_bit0", data_shift_data, 1);

      // ena during RD: underrun, word still intact
      load_addr(8'h20);
      w = 16'h1234;
      data_shift_update = 1'b1;
      tick();
      data_shift_update = 1'b0;
      check("ur_rd_ena", mem_rd_ena, 1);
      ena_pulse();
      check("ur_flag", underrun, 1);
      tick();
      check("ur_bit0", data_shift_data, w[0]);
      for (int k = 1; k < 6; k++) begin
         ena_pulse();
         check($sformatf("ur_bit%0d", k), data_shift_data, w[k]);
      end
      check("ur_sticky", underrun, 1);
      load_addr(8'h10);
      check("ur_cleared", underrun, 0);

      // Restart after 5 shifts; update+ena same cycle drops the ena
      w = 16'hA5C3;
      fetch("rs_a", 8'h10, w);
      for (int k = 0; k < 5; k++) ena_pulse();
      check("rs_bit5", data_shift_data, w[5]);
      data_shift_update = 1'b1;
      data_shift_ena = 1'b1;
      tick();
      data_shift_update = 1'b0;
      data_shift_ena = 1'b0;
      check("upd_ena_rd", mem_rd_ena, 1);
      check("upd_ena_addr", mem_rd_addr, 8'h10);
      check("upd_ena_hold", data_shift_data, w[5]);
      check("upd_ena_underrun", underrun, 0);
      tick();
      tick();
      check("rs_bit0", data_shift_data, w[0]);
      for (int k = 1; k < 16; k++) ena_pulse();
      check("rs_bit15", data_shift_data, w[15]);
      check("rs_addr_15", rd_addr, 8'h10);
      ena_pulse();
      check("rs_addr_16", rd_addr, 8'h11);

      // Async reset during LOAD
      load_addr(8'h10);
      fetch("pre", 8'h10, 16'hA5C3);
      ena_pulse();
      data_shift_update = 1'b1;
      tick();
      data_shift_update = 1'b0;
      tick();
      scan_reset = 1'b1;
      #1;
      check("async_data", data_shift_data, 0);
      check("async_addr", rd_addr, 0);
      check("async_ena", mem_rd_ena, 0);
      tick();
      check("rst_hold_ena", mem_rd_ena, 0);
      check("rst_hold_data", data_shift_data, 0);
      scan_reset = 1'b0;

      // Simultaneous load + update: load wins, stays IDLE
      rd_start_load = 1'b1;
      rd_start_addr = 8'h42;
      data_shift_update = 1'b1;
      tick();
      rd_start_load = 1'b0;
      data_shift_update = 1'b0;
      check("lu_addr", rd_addr, 8'h42);
      check("lu_ena", mem_rd_ena, 0);
      tick();
      check("lu_ena2", mem_rd_ena, 0);
      check("lu_data", data_shift_data, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
